// File: rtl/mips32_pkg.sv
// mips32_pkg: shared opcodes, register-file geometry and scoreboard defaults
// for the MIPS32 pipeline.
package mips32_pkg;

  localparam int NREG   = 32;
  localparam int RIDX_W = $clog2(NREG);

  localparam int DEF_ALU_LAT  = 2;
  localparam int DEF_LOAD_LAT = 2;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  function automatic int cnt_width(int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mips32_hazard_scoreboard_if.sv
// mips32_hazard_scoreboard_if: ID-stage operand request bundle and the
// scoreboard's stall/issue answer.
interface mips32_hazard_scoreboard_if #(
  parameter int RIDX_W = mips32_pkg::RIDX_W
);

  logic              id_valid;
  logic [RIDX_W-1:0] id_rs;
  logic              id_rs_used;
  logic [RIDX_W-1:0] id_rt;
  logic              id_rt_used;
  logic [RIDX_W-1:0] id_rd;
  logic              id_rd_we;
  logic              id_is_load;
  logic              stall;
  logic              issue;

  modport master (
    output id_valid, id_rs, id_rs_used,
    output id_rt, id_rt_used,
    output id_rd, id_rd_we, id_is_load,
    input  stall, issue
  );

  modport slave (
    input  id_valid, id_rs, id_rs_used,
    input  id_rt, id_rt_used,
    input  id_rd, id_rd_we, id_is_load,
    output stall, issue
  );

endinterface

// File: rtl/mips32_sb_entry.sv
// mips32_sb_entry: writeback countdown for one architectural register,
// plus its source and destination hazard compares.
module mips32_sb_entry #(
  parameter int CW       = 2,
  parameter int LOAD_LAT = 2,
  parameter bit FWD_EN   = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hold,
  input  logic          set,
  input  logic [CW-1:0] new_lat,
  input  logic          set_ld,
  output logic          busy,
  output logic          src_haz,
  output logic          waw_haz
);

  localparam logic [CW-1:0] LD_THR = CW'(LOAD_LAT - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          ld_q, ld_d;

  always_comb begin
    cnt_d = cnt_q;
    ld_d  = ld_q;
    if (!hold && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    if (set) begin
      cnt_d = new_lat;
      ld_d  = set_ld;
    end
  end

  // Forwarding hides ALU results; only the load's first cycle is unsafe.
  always_comb begin
    busy    = cnt_q != '0;
    waw_haz = cnt_q > new_lat;
    if (FWD_EN) begin
      src_haz = ld_q && (cnt_q > LD_THR);
    end else begin
      src_haz = busy;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ld_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ld_q  <= ld_d;
    end
  end

endmodule

// File: rtl/mips32_hazard_scoreboard.sv
// mips32_hazard_scoreboard: ID-stage RAW/WAW scoreboard that holds issue
// until every source is readable and no older write would land later.
module mips32_hazard_scoreboard #(
  parameter int NREG     = mips32_pkg::NREG,
  parameter int RIDX_W   = $clog2(NREG),
  parameter int ALU_LAT  = mips32_pkg::DEF_ALU_LAT,
  parameter int LOAD_LAT = mips32_pkg::DEF_LOAD_LAT,
  parameter bit FWD_EN   = 1'b0,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  mips32_hazard_scoreboard_if.slave sb,
  input  logic                      flush,
  input  logic                      halted,
  output logic [NREG-1:0]           busy_vec,
  output logic [CNT_W-1:0]          stall_cycles
);

  import mips32_pkg::*;

  localparam int            CW    = cnt_width(LOAD_LAT);
  localparam logic [CW-1:0] ALU_L = CW'(ALU_LAT);
  localparam logic [CW-1:0] LD_L  = CW'(LOAD_LAT);

  logic [NREG-1:0]  busy, src_haz, waw_haz;
  logic [CW-1:0]    new_lat;
  logic             active, rs_haz, rt_haz, waw;
  logic             stall_c, issue_c, wr_en;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  assign new_lat = sb.id_is_load ? LD_L : ALU_L;

  assign busy[0]    = 1'b0;
  assign src_haz[0] = 1'b0;
  assign waw_haz[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_ent
    mips32_sb_entry #(
      .CW       (CW),
      .LOAD_LAT (LOAD_LAT),
      .FWD_EN   (FWD_EN)
    ) u_ent (
      .clk     (clk),
      .rst_n   (rst_n),
      .hold    (halted),
      .set     (wr_en && (sb.id_rd == RIDX_W'(r))),
      .new_lat (new_lat),
      .set_ld  (sb.id_is_load),
      .busy    (busy[r]),
      .src_haz (src_haz[r]),
      .waw_haz (waw_haz[r])
    );
  end

  // Outputs are forced quiet while reset is asserted.
  always_comb begin
    active  = rst_n && sb.id_valid && !flush && !halted;
    rs_haz  = sb.id_rs_used && src_haz[sb.id_rs];
    rt_haz  = sb.id_rt_used && src_haz[sb.id_rt];
    waw     = sb.id_rd_we && waw_haz[sb.id_rd];
    stall_c = active && (rs_haz || rt_haz || waw);
    issue_c = active && !stall_c;
    wr_en   = issue_c && sb.id_rd_we && (sb.id_rd != '0);
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_c && stall_cycles_q != '1) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign sb.stall     = stall_c;
  assign sb.issue     = issue_c;
  assign busy_vec     = busy;
  assign stall_cycles = stall_cycles_q;

endmodule
